// File: rtl/bitmap_bit_iterator.sv
// Walks a bitmap LSB-first, emitting one beat per set bit (or a single
// beat flagged empty for an all-zero bitmap) over a valid/ready handshake.
`timescale 1ns/1ps
module bitmap_bit_iterator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DATA_WIDTH)-1:0] out_idx,
  output logic [$clog2(DATA_WIDTH)-1:0] out_rank,
  output logic                          out_last,
  output logic                          out_empty,
  output logic                          busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  state_p0, state_nxt;
  logic [DATA_WIDTH-1:0]   rem_p0;
  logic [DATA_WIDTH-1:0]   rem_clr;
  logic [IDX_W-1:0]        rank_p0;
  logic                    empty_p0;
  logic                    single_bit;

  // Scans from the top so the last hit wins, leaving the lowest set position.
  function automatic logic [IDX_W-1:0] tzc(input logic [DATA_WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign rem_clr    = rem_p0 & (rem_p0 - 1'b1);
  assign single_bit = (rem_p0 != '0) && (rem_clr == '0);

  assign out_idx   = tzc(rem_p0);
  assign out_rank  = rank_p0;
  assign out_last  = empty_p0 | single_bit;
  assign out_empty = empty_p0;
  assign busy      = (state_p0 == EMIT);

  always_comb begin
    state_nxt = state_p0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_p0)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: held bitmap, beat ordinal and empty marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      rem_p0   <= '0;
      rank_p0  <= '0;
      empty_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (state_p0 == IDLE && in_valid) begin
        rem_p0   <= din;
        rank_p0  <= '0;
        empty_p0 <= (din == '0);
      end else if (state_p0 == EMIT && out_ready) begin
        if (out_last) begin
          rem_p0   <= '0;
          rank_p0  <= '0;
          empty_p0 <= 1'b0;
        end else begin
          rem_p0  <= rem_clr;
          rank_p0 <= rank_p0 + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitmap_bit_iterator.sv
// Bench for bitmap_bit_iterator: directed scenarios plus random bitmaps
// checked against a per-bit list model of the expected beat sequence.
`timescale 1ns/1ps
module tb_bitmap_bit_iterator;

  localparam int W  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready;
  logic          in_ready, out_valid, out_last, out_empty, busy;
  logic [W-1:0]  din;
  logic [IW-1:0] out_idx, out_rank;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] rank;
    logic       last;
    logic       empty;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];
  int    xfer_cycles, xfer_unstable, xfer_timeout;

  always #5 clk = ~clk;

  bitmap_bit_iterator #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_rank(out_rank), .out_last(out_last),
    .out_empty(out_empty), .busy(busy)
  );

  // Expected beats: one per set bit in ascending position, or one empty beat.
  function automatic void model(input logic [W-1:0] bm);
    beat_t b;
    int    r;
    r = 0;
    exp_q.delete();
    if (bm == '0) begin
      b.idx = 8'd0; b.rank = 8'd0; b.last = 1'b1; b.empty = 1'b1;
      exp_q.push_back(b);
      return;
    end
    for (int i = 0; i < W; i++) begin
      if (bm[i]) begin
        b.idx = 8'(i); b.rank = 8'(r); b.last = 1'b0; b.empty = 1'b0;
        exp_q.push_back(b);
        r++;
      end
    end
    b = exp_q.pop_back();
    b.last = 1'b1;
    exp_q.push_back(b);
  endfunction

  // Sends one bitmap and records the beats; stalls smin..smax cycles before
  // each beat while noting any output change, and stops after max_beats.
  task automatic xfer(input logic [W-1:0] bm, input int smin, input int smax,
                      input int max_beats);
    beat_t b;
    int    w, n;
    got.delete();
    xfer_cycles = 0; xfer_unstable = 0; xfer_timeout = 0;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin xfer_timeout = 1; return; end
    in_valid = 1'b1; din = bm;
    @(posedge clk); #1;
    forever begin
      in_valid = 1'($urandom_range(0, 1));
      din      = $urandom;
      @(negedge clk); xfer_cycles++;
      w = 0;
      while (!out_valid && w < 50) begin @(negedge clk); xfer_cycles++; w++; end
      if (!out_valid) begin xfer_timeout = 1; break; end
      b.idx = 8'(out_idx); b.rank = 8'(out_rank); b.last = out_last; b.empty = out_empty;
      n = $urandom_range(smin, smax);
      out_ready = 1'b0;
      repeat (n) begin
        @(negedge clk); xfer_cycles++;
        if (!out_valid || 8'(out_idx) != b.idx || 8'(out_rank) != b.rank ||
            out_last != b.last || out_empty != b.empty) xfer_unstable++;
      end
      out_ready = 1'b1;
      got.push_back(b);
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      if (b.last || got.size() >= max_beats) break;
      if (got.size() > W) begin xfer_timeout = 1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; din = 32'h0000_00FF; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_empty, busy, out_idx, out_rank} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b last=%b empty=%b busy=%b idx=%0d rank=%0d required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_last, out_empty, busy, out_idx, out_rank);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_single();
    xfer(32'h0000_0001, 0, 0, 99);
    model(32'h0000_0001);
    checks++;
    if (xfer_timeout != 0 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count got %0d beats (timeout=%0d) required %0d", got.size(), xfer_timeout, exp_q.size());
    end else for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat %0d got %h required %h", i, got[i], exp_q[i]); end
    end
    checks++;
    if (xfer_cycles != 1) begin errors++; $display("FAIL single_latency got %0d required 1", xfer_cycles); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_ready_return got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_two_bits();
    xfer(32'h8000_0001, 0, 0, 99);
    model(32'h8000_0001);
    checks++;
    if (xfer_timeout != 0 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL two_bits_count got %0d beats (timeout=%0d) required %0d", got.size(), xfer_timeout, exp_q.size());
    end else for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL two_bits_beat %0d got %h required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty_back_to_back();
    xfer(32'h0000_0000, 0, 0, 99);
    model(32'h0000_0000);
    checks++;
    if (xfer_timeout != 0 || got.size() != 1 || got[0] !== exp_q[0] || xfer_cycles != 1) begin
      errors++;
      $display("FAIL empty_beat got n=%0d beat=%h cycles=%0d required n=1 beat=%h cycles=1",
               got.size(), (got.size() > 0) ? got[0] : beat_t'(0), xfer_cycles, exp_q[0]);
    end
    xfer(32'h0000_0010, 0, 0, 99);
    model(32'h0000_0010);
    checks++;
    if (xfer_timeout != 0 || got.size() != 1 || got[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL after_empty_beat got n=%0d beat=%h required n=1 beat=%h",
               got.size(), (got.size() > 0) ? got[0] : beat_t'(0), exp_q[0]);
    end
  endtask

  task automatic test_all_ones();
    xfer(32'hFFFF_FFFF, 0, 0, 99);
    model(32'hFFFF_FFFF);
    checks++;
    if (xfer_timeout != 0 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL all_ones_count got %0d beats (timeout=%0d) required %0d", got.size(), xfer_timeout, exp_q.size());
    end else for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL all_ones_beat %0d got %h required %h", i, got[i], exp_q[i]); end
    end
    checks++;
    if (xfer_cycles != 32) begin errors++; $display("FAIL all_ones_throughput got %0d cycles required 32", xfer_cycles); end
  endtask

  task automatic test_backpressure();
    xfer(32'h0000_0A00, 5, 5, 99);
    model(32'h0000_0A00);
    checks++;
    if (xfer_timeout != 0 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count got %0d beats (timeout=%0d) required %0d", got.size(), xfer_timeout, exp_q.size());
    end else for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat %0d got %h required %h", i, got[i], exp_q[i]); end
    end
    checks++;
    if (xfer_unstable != 0) begin errors++; $display("FAIL stall_stability got %0d changes required 0", xfer_unstable); end
    checks++;
    if (xfer_cycles != 12) begin errors++; $display("FAIL stall_cycles got %0d required 12", xfer_cycles); end
  endtask

  task automatic test_reset_mid();
    int extra;
    xfer(32'h0000_00F0, 0, 0, 2);
    checks++;
    if (got.size() != 2 || got[0].idx != 8'd4 || got[1].idx != 8'd5 || got[1].rank != 8'd1) begin
      errors++;
      $display("FAIL mid_reset_prefix got n=%0d required beats idx 4,5", got.size());
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL mid_reset_state got vld=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
    out_ready = 1'b1;
    extra = 0;
    repeat (4) begin @(negedge clk); if (out_valid) extra++; end
    out_ready = 1'b0;
    checks++;
    if (extra != 0) begin errors++; $display("FAIL mid_reset_no_beats got %0d beats required 0", extra); end
    xfer(32'h0000_0004, 0, 0, 99);
    model(32'h0000_0004);
    checks++;
    if (xfer_timeout != 0 || got.size() != 1 || got[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL mid_reset_next got n=%0d beat=%h required n=1 beat=%h",
               got.size(), (got.size() > 0) ? got[0] : beat_t'(0), exp_q[0]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] bm;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0:       bm = ($urandom_range(0, 1) == 0) ? '0 : (32'h1 << $urandom_range(0, 31));
        1:       bm = $urandom;
        2:       bm = $urandom & $urandom & $urandom;
        default: bm = ~($urandom & $urandom & $urandom);
      endcase
      xfer(bm, 0, 2, 99);
      model(bm);
      checks++;
      if (xfer_timeout != 0 || got.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random_count bm=%h got %0d beats (timeout=%0d) required %0d", bm, got.size(), xfer_timeout, exp_q.size());
      end else for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++; $display("FAIL random_beat bm=%h beat %0d got %h required %h", bm, i, got[i], exp_q[i]);
        end
      end
      checks++;
      if (xfer_unstable != 0) begin errors++; $display("FAIL random_stability bm=%h got %0d changes required 0", bm, xfer_unstable); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    test_reset();
    test_single();
    test_two_bits();
    test_empty_back_to_back();
    test_all_ones();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
